// File: rtl/multicycle_issue_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_issue_ctrl_pkg : shared states, unit IDs and mode codes
// Revision: 1.0
// ---------------------------------------------------------------------------
package multicycle_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    MIC_IDLE  = 2'd0,
    MIC_START = 2'd1,
    MIC_WAIT  = 2'd2,
    MIC_WB    = 2'd3
  } mic_state_e;

  localparam int UNIT_MUL = 0;
  localparam int UNIT_DIV = 1;
  localparam int UNIT_FPU = 2;

  // Mode codes understood by the multiplier and divider datapaths.
  localparam logic [1:0] MODE_MUL_LO    = 2'd0;
  localparam logic [1:0] MODE_MUL_UMULH = 2'd1;
  localparam logic [1:0] MODE_MUL_SMULH = 2'd2;
  localparam logic [1:0] MODE_DIV_UDIV  = 2'd0;
  localparam logic [1:0] MODE_DIV_SDIV  = 2'd1;
  localparam logic [1:0] MODE_DIV_UREM  = 2'd2;
  localparam logic [1:0] MODE_DIV_SREM  = 2'd3;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_issue_ctrl_watchdog.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_issue_ctrl_watchdog : saturating WAIT-cycle counter with expiry
// Revision: 1.0
// ---------------------------------------------------------------------------
module multicycle_issue_ctrl_watchdog
  import multicycle_issue_ctrl_pkg::*;
#(
  parameter  int TIMEOUT_CYCLES = 256,
  localparam int CNT_W          = clog2_min1(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W-1:0] CNT_SAT = (TIMEOUT_CYCLES == 0) ? {CNT_W{1'b1}}
                                                               : CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts completed WAIT cycles, so the current one is the TIMEOUT-th at TIMEOUT-1.
  if (TIMEOUT_CYCLES > 0) begin : g_expire
    assign expire = en && (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));
  end else begin : g_no_expire
    assign expire = 1'b0;
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_issue_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_issue_ctrl : start/done sequencer for long-latency execute units
// Revision: 1.0
// ---------------------------------------------------------------------------
module multicycle_issue_ctrl
  import multicycle_issue_ctrl_pkg::*;
#(
  parameter  int NUM_UNITS      = 3,
  parameter  int MODE_W         = 2,
  parameter  int REG_W          = 5,
  parameter  int TIMEOUT_CYCLES = 256,
  localparam int UNIT_W         = clog2_min1(NUM_UNITS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 req_valid,
  input  logic [UNIT_W-1:0]    req_unit,
  input  logic [MODE_W-1:0]    req_mode,
  input  logic [REG_W-1:0]     req_dest,
  output logic [NUM_UNITS-1:0] unit_start,
  output logic [NUM_UNITS-1:0] unit_abort,
  output logic [MODE_W-1:0]    unit_mode,
  input  logic [NUM_UNITS-1:0] unit_done,
  output logic                 wb_valid,
  output logic [REG_W-1:0]     wb_dest,
  output logic [UNIT_W-1:0]    wb_src,
  output logic                 pc_hold,
  output logic                 busy,
  output logic                 timeout_err
);

  mic_state_e           state_q, state_d;
  logic [UNIT_W-1:0]    unit_q, unit_d;
  logic [MODE_W-1:0]    mode_q, mode_d;
  logic [REG_W-1:0]     dest_q, dest_d;
  logic [NUM_UNITS-1:0] start_q, start_d;
  logic [NUM_UNITS-1:0] abort_q, abort_d;
  logic                 terr_q, terr_d;
  logic [NUM_UNITS-1:0] unit_oh;
  logic                 unit_in_range;
  logic                 accept;
  logic                 done_sel;
  logic                 wd_clr, wd_en, wd_expire;

  function automatic logic [NUM_UNITS-1:0] decode_unit(input logic [UNIT_W-1:0] u);
    logic [NUM_UNITS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      oh[i] = (u == UNIT_W'(i));
    end
    return oh;
  endfunction

  // Extra MSB keeps the range check correct when NUM_UNITS is a power of two.
  assign unit_in_range = ({1'b0, req_unit} < (UNIT_W + 1)'(NUM_UNITS));
  assign accept        = (state_q == MIC_IDLE) && req_valid && !stall && !flush && unit_in_range;
  assign unit_oh       = decode_unit(unit_q);
  assign done_sel      = |(unit_done & unit_oh);

  always_comb begin
    state_d  = state_q;
    unit_d   = unit_q;
    mode_d   = mode_q;
    dest_d   = dest_q;
    abort_d  = '0;
    terr_d   = terr_q;
    wd_clr   = 1'b0;
    wd_en    = 1'b0;
    wb_valid = 1'b0;
    case (state_q)
      MIC_IDLE: begin
        if (accept) begin
          unit_d  = req_unit;
          mode_d  = req_mode;
          dest_d  = req_dest;
          state_d = MIC_START;
        end
      end
      MIC_START: begin
        wd_clr = 1'b1;
        if (flush) begin
          abort_d = unit_oh;
          state_d = MIC_IDLE;
        end else begin
          state_d = MIC_WAIT;
        end
      end
      MIC_WAIT: begin
        wd_en = 1'b1;
        // flush beats done, done beats the watchdog
        if (flush) begin
          abort_d = unit_oh;
          state_d = MIC_IDLE;
        end else if (done_sel) begin
          state_d = MIC_WB;
        end else if (wd_expire) begin
          abort_d = unit_oh;
          terr_d  = 1'b1;
          state_d = MIC_IDLE;
        end
      end
      MIC_WB: begin
        if (flush) begin
          state_d = MIC_IDLE;
        end else if (!stall) begin
          wb_valid = 1'b1;
          state_d  = MIC_IDLE;
        end
      end
      default: state_d = MIC_IDLE;
    endcase
    start_d = (state_d == MIC_START) ? decode_unit(unit_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MIC_IDLE;
      unit_q  <= '0;
      mode_q  <= '0;
      dest_q  <= '0;
      start_q <= '0;
      abort_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      unit_q  <= unit_d;
      mode_q  <= mode_d;
      dest_q  <= dest_d;
      start_q <= start_d;
      abort_q <= abort_d;
      terr_q  <= terr_d;
    end
  end

  multicycle_issue_ctrl_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );

  assign unit_start  = start_q;
  assign unit_abort  = abort_q;
  assign unit_mode   = mode_q;
  assign wb_dest     = dest_q;
  assign wb_src      = unit_q;
  assign busy        = (state_q != MIC_IDLE);
  assign timeout_err = terr_q;
  assign pc_hold     = stall || accept || (state_q == MIC_START) || (state_q == MIC_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_issue_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_multicycle_issue_ctrl : directed and random ops against a transaction model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_multicycle_issue_ctrl;

  localparam int TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall, flush, req_valid;
  logic [1:0] req_unit, req_mode;
  logic [4:0] req_dest;
  logic [2:0] unit_start, unit_abort, unit_done;
  logic [1:0] unit_mode, wb_src;
  logic       wb_valid, pc_hold, busy, timeout_err;
  logic [4:0] wb_dest;

  int checks = 0;
  int errors = 0;
  int op_id  = 0;
  bit terr_m = 1'b0;

  multicycle_issue_ctrl #(
    .NUM_UNITS      (3),
    .MODE_W         (2),
    .REG_W          (5),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_unit    (req_unit),
    .req_mode    (req_mode),
    .req_dest    (req_dest),
    .unit_start  (unit_start),
    .unit_abort  (unit_abort),
    .unit_mode   (unit_mode),
    .unit_done   (unit_done),
    .wb_valid    (wb_valid),
    .wb_dest     (wb_dest),
    .wb_src      (wb_src),
    .pc_hold     (pc_hold),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (op %0d): observed %0h, expected %0h", tag, op_id, obs, exp);
    end
  endtask

  // Outcome derived from timing arithmetic: accept at k=0, start at k=1,
  // done first seen at k=1+d, watchdog gives up after WAIT cycles k=2..TIMEOUT+1.
  task automatic run_op(input int unit, input int mode, input int dest, input int d,
                        input int f, input int sl, input bit rnd_stall);
    int dc, to_k, term, outc, last, wbk, hold_end;
    logic [2:0] oh;
    logic       stall_k;
    dc   = 1 + d;
    to_k = TIMEOUT + 1;
    term = (dc <= to_k) ? dc : to_k;
    wbk  = -1;
    if (f >= 1 && f <= term) begin
      outc = 1; last = f;
    end else if (dc <= to_k) begin
      wbk = dc + 1 + sl;
      if (f >= dc + 1 && f <= wbk) begin
        outc = 3; last = f; wbk = -1;
      end else begin
        outc = 0; last = wbk;
      end
    end else begin
      outc = 2; last = to_k;
    end
    hold_end = (outc == 0 || outc == 3) ? dc : last;
    oh = 3'b001 << unit;
    op_id++;
    for (int k = 0; k <= last + 1; k++) begin
      @(posedge clk); #1;
      if (k >= 1 && k <= hold_end)
        stall_k = rnd_stall ? 1'($urandom_range(0, 1)) : 1'b0;
      else if ((outc == 0 || outc == 3) && k > dc && k <= dc + sl)
        stall_k = 1'b1;
      else
        stall_k = 1'b0;
      stall = stall_k;
      flush = (k == f);
      if (k == 0) begin
        req_valid = 1'b1;
        req_unit  = 2'(unit);
        req_mode  = 2'(mode);
        req_dest  = 5'(dest);
      end else if (k <= last) begin
        req_valid = 1'($urandom_range(0, 1));
        req_unit  = 2'($urandom_range(0, 3));
        req_mode  = 2'($urandom_range(0, 3));
        req_dest  = 5'($urandom_range(0, 31));
      end else begin
        req_valid = 1'b0;
      end
      unit_done = 3'($urandom_range(0, 7)) & ~oh;
      if (k >= dc) unit_done = unit_done | oh;
      @(negedge clk);
      check("busy", busy, (k >= 1 && k <= last));
      check("unit_start", unit_start, (k == 1) ? oh : 3'b000);
      check("unit_abort", unit_abort,
            (k == last + 1 && (outc == 1 || outc == 2)) ? oh : 3'b000);
      check("wb_valid", wb_valid, (outc == 0 && k == wbk));
      check("pc_hold", pc_hold, stall_k || (k <= hold_end));
      check("timeout_err", timeout_err, terr_m || (outc == 2 && k == last + 1));
      if (k >= 1) begin
        check("wb_dest", wb_dest, dest);
        check("wb_src", wb_src, unit);
        check("unit_mode", unit_mode, mode);
      end
    end
    if (outc == 2) terr_m = 1'b1;
    stall = 1'b0; flush = 1'b0; unit_done = 3'b000; req_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int d, f, sl, term;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; req_valid = 1'b0;
    req_unit = '0; req_mode = '0; req_dest = '0; unit_done = '0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_start", unit_start, 0);
    check("rst_abort", unit_abort, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_pc_hold", pc_hold, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_wb_dest", wb_dest, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    run_op(0, 1, 7, 4, -1, 0, 1'b0);    // MUL, done 4 cycles after start
    run_op(1, 2, 12, 2, -1, 2, 1'b0);   // DIV, writeback stalled 2 cycles
    run_op(1, 0, 3, 3, 4, 0, 1'b0);     // flush together with done
    run_op(0, 3, 21, 3, 1, 0, 1'b0);    // flush in START
    run_op(1, 1, 9, 2, 4, 2, 1'b0);     // flush while stalled in WB
    run_op(2, 3, 30, 20, -1, 0, 1'b0);  // unit never completes
    run_op(2, 1, 5, 1, -1, 0, 1'b0);    // minimum latency after timeout
    run_op(0, 2, 17, 8, -1, 1, 1'b1);   // done on the last WAIT cycle

    // Out-of-range unit, then accept blocked by flush
    @(posedge clk); #1;
    req_valid = 1'b1; req_unit = 2'd3; req_mode = 2'd1; req_dest = 5'd4;
    @(negedge clk);
    check("oor_pc_hold", pc_hold, 0);
    check("oor_busy", busy, 0);
    @(posedge clk); #1;
    req_unit = 2'd0; flush = 1'b1;
    @(negedge clk);
    check("oor_start", unit_start, 0);
    check("oor_busy_next", busy, 0);
    check("flush_idle_pc_hold", pc_hold, 0);
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_idle_start", unit_start, 0);
    check("flush_idle_busy", busy, 0);

    // Asynchronous reset while waiting on unit 0
    @(posedge clk); #1;
    req_valid = 1'b1; req_unit = 2'd0; req_mode = 2'd2; req_dest = 5'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_pc_hold", pc_hold, 0);
    check("arst_timeout_err", timeout_err, 0);
    check("arst_wb_dest", wb_dest, 0);
    check("arst_wb_src", wb_src, 0);
    check("arst_unit_mode", unit_mode, 0);
    check("arst_start", unit_start, 0);
    check("arst_abort", unit_abort, 0);
    terr_m = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("post_rst_abort", unit_abort, 0);
    run_op(0, 2, 9, 3, -1, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      d    = $urandom_range(1, 10);
      sl   = $urandom_range(0, 3);
      term = (1 + d <= TIMEOUT + 1) ? 1 + d : TIMEOUT + 1;
      f    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, term + sl + 1) : -1;
      run_op($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 31),
             d, f, sl, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
